i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters (legal range 2..8).
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the WAIT-state watchdog limit (used only with I2C_ARB_TIMEOUT_EN).
REQ-004 The ports SHALL be as follows:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NREQ  per-requester transaction request, level, held until ack
- req_wr  in  NREQ  per-requester direction (1 = write, 0 = read)
- req_addr  in  7*NREQ  per-requester 7-bit target address, requester i at bits [7i+6:7i]
- req_din  in  8*NREQ  per-requester write data, requester i at bits [8i+7:8i]
- gnt  out  NREQ  one-hot grant, held for the whole transaction
- ack  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  8  read data returned with ack
- err  out  1  valid with ack; 1 = transaction aborted
- eng_start  out  1  one-cycle start pulse to the I2C engine
- eng_wr  out  1  latched direction to the engine
- eng_addr  out  7  latched address to the engine
- eng_din  out  8  latched write data to the engine
- eng_datard  in  8  engine read data
- eng_done  in  1  engine completion pulse

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-006 In IDLE, when any req bit is 1, the block SHALL select a winner round-robin, searching from (last winner + 1) mod NREQ upward.
REQ-007 On selection, the block SHALL latch the winner's req_wr, req_addr and req_din into eng_wr, eng_addr and eng_din, set gnt to the winner, and move to ISSUE on the next cycle.
REQ-008 In ISSUE, eng_start SHALL be 1 for exactly one cycle, and the FSM SHALL then move to WAIT.
REQ-009 eng_wr, eng_addr, eng_din and gnt SHALL remain stable from ISSUE through RESP.
REQ-010 In WAIT, on eng_done = 1 the block SHALL capture eng_datard into rdata if eng_wr = 0, leave rdata unchanged if eng_wr = 1, and move to RESP.
REQ-011 eng_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-012 In RESP, ack[winner] SHALL be 1 for one cycle and err SHALL hold that transaction's status. The block SHALL then update the last-winner pointer, clear gnt, and return to IDLE.
REQ-013 The best-case latency from req sampled in IDLE to ack SHALL be 3 cycles plus the engine's done latency, which is at least 1 cycle.
REQ-014 A requester SHALL deassert req in the cycle after ack. A req still high in IDLE SHALL be treated as a new request, at lowest priority after the pointer update.
REQ-015 If a requester drops req after being granted, the transaction SHALL still complete, and ack SHALL still pulse.
REQ-016 Simultaneous requests SHALL be served in round-robin order, so no requester waits more than NREQ-1 transactions.
REQ-017 rdata and err SHALL hold their last values until the next RESP.

Reset
REQ-018 When rst = 1 at a clk edge, the FSM SHALL go to IDLE from any state, including mid-transaction.
REQ-019 On reset, gnt, ack, eng_start, eng_wr, eng_addr, eng_din, rdata and err SHALL be 0.
REQ-020 On reset, the last-winner pointer SHALL be NREQ-1, so requester 0 has first priority.
REQ-021 No ack SHALL be issued for a transaction aborted by reset.

Configuration
REQ-022 With macro I2C_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment every WAIT cycle. When it reaches TIMEOUT_CYCLES without eng_done, the FSM SHALL move to RESP with err = 1 and rdata unchanged.
REQ-023 With I2C_ARB_TIMEOUT_EN undefined, WAIT SHALL wait indefinitely for eng_done, no counter logic SHALL exist, and err SHALL be tied to 0.

Verification
REQ-024 Reset, then req = 0001, req_wr[0] = 1, addr0 = 7'h2A, din0 = 8'hC3; engine done 5 cycles after eng_start -> eng_start once, eng_addr = 2A, eng_din = C3, ack[0] one cycle, err = 0.
REQ-025 Read: req[2] with addr 7'h11; engine returns eng_datard = 8'h5E with done -> rdata = 5E when ack[2] = 1.
REQ-026 req = 1111 held, each released after its ack -> grant order 0,1,2,3, with exactly one ack per requester.
REQ-027 After requester 1 is served, req = 0011 -> requester 0 granted next, not requester 1.
REQ-028 With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, eng_done never asserted -> ack with err = 1 exactly 16 WAIT cycles after entry, rdata unchanged.
REQ-029 Assert rst during WAIT -> all outputs 0 next cycle, no ack, and a subsequent req = 1000 is served normally.

Source files
------------

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C engine among NREQ requesters.
// Optional WAIT watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_din,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rdata,
  output logic              err,
  output logic              eng_start,
  output logic              eng_wr,
  output logic [6:0]        eng_addr,
  output logic [7:0]        eng_din,
  input  logic [7:0]        eng_datard,
  input  logic              eng_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = IW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("i2c_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  logic [1:0]    state;
  logic [IW-1:0] last;
  logic [IW-1:0] win_q;
  logic [IW-1:0] cand;
  logic [SW-1:0] sum;
  logic          found;
  logic          sel_wr;
  logic [6:0]    sel_addr;
  logic [7:0]    sel_din;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcnt;
`endif

  // Search upward from last+1, wrapping modulo NREQ; the first set req wins.
  always_comb begin
    found = 1'b0;
    cand  = last;
    sum   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, last} + SW'(k);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        cand  = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cand == IW'(i)) begin
        sel_wr   = req_wr[i];
        sel_addr = req_addr[7*i +: 7];
        sel_din  = req_din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IW'(NREQ - 1);
      win_q     <= '0;
      gnt       <= '0;
      ack       <= '0;
      eng_start <= 1'b0;
      eng_wr    <= 1'b0;
      eng_addr  <= '0;
      eng_din   <= '0;
      rdata     <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      err       <= 1'b0;
      tcnt      <= '0;
`endif
    end else begin
      eng_start <= 1'b0;
      ack       <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            win_q     <= cand;
            gnt       <= NREQ'(1) << cand;
            eng_wr    <= sel_wr;
            eng_addr  <= sel_addr;
            eng_din   <= sel_din;
            eng_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        WAIT: begin
          if (eng_done) begin
            if (!eng_wr) rdata <= eng_datard;
            ack   <= gnt;
            state <= RESP;
`ifdef I2C_ARB_TIMEOUT_EN
            err   <= 1'b0;
          end else if (tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
            // Watchdog expiry: abort with error, read data left untouched.
            ack   <= gnt;
            err   <= 1'b1;
            state <= RESP;
          end else begin
            tcnt  <= tcnt + CW'(1);
`endif
          end
        end
        RESP: begin
          gnt   <= '0;
          last  <= win_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef I2C_ARB_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a simple behavioural I2C engine.
module tb_i2c_arbiter;
  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req, req_wr;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_din;
  logic [NREQ-1:0] gnt, ack;
  logic [7:0]      rdata;
  logic            err, eng_start, eng_wr;
  logic [6:0]      eng_addr;
  logic [7:0]      eng_din, eng_datard;
  logic            eng_done;

  i2c_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_din(req_din), .gnt(gnt), .ack(ack), .rdata(rdata), .err(err),
    .eng_start(eng_start), .eng_wr(eng_wr), .eng_addr(eng_addr),
    .eng_din(eng_din), .eng_datard(eng_datard), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0;
  int eng_lat = 1;
  bit eng_en = 1'b1;
  logic [7:0] eng_rd_val = 8'h00;
  int cd = 0;

  int starts, unstable, st_cyc, ack_cyc;
  logic [NREQ-1:0] st_gnt;
  logic [6:0] st_addr;
  logic [7:0] st_din;
  logic st_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_req(input int r, input logic wr, input logic [6:0] addr, input logic [7:0] din);
    req_wr[r] = wr;
    req_addr[7*r +: 7] = addr;
    req_din[8*r +: 8] = din;
    req[r] = 1'b1;
  endtask

  // Waits (bounded) for an ack, tracking the engine command and its stability.
  task automatic wait_ack(output logic [NREQ-1:0] a);
    int n;
    n = 0;
    starts = 0;
    unstable = 0;
    while (ack == '0 && n < 300) begin
      if (eng_start) begin
        starts++;
        st_cyc = cyc; st_gnt = gnt; st_addr = eng_addr; st_din = eng_din; st_wr = eng_wr;
      end else if (starts > 0 && (gnt !== st_gnt || eng_addr !== st_addr ||
                                  eng_din !== st_din || eng_wr !== st_wr)) begin
        unstable++;
      end
      tick();
      n++;
    end
    a = ack;
    ack_cyc = cyc;
    if (starts > 0 && (gnt !== st_gnt || eng_addr !== st_addr || eng_din !== st_din || eng_wr !== st_wr))
      unstable++;
    check("ack_seen", 32'(a != '0), 32'd1);
  endtask

  initial begin
    eng_done = 1'b0;
    eng_datard = 8'h00;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          eng_done = 1'b1;
          eng_datard = eng_rd_val;
        end
      end
      if (eng_start && eng_en) cd = eng_lat;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] a;
    int per_ack [NREQ];
    int extra;
    rst = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_din = '0;
    tick(); tick();
    check("rst_ctl", 32'({gnt, ack, eng_start, err}), 32'd0);
    check("rst_eng", 32'({eng_wr, eng_addr, eng_din}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    tick();

    // Single write from requester 0, engine done 5 cycles after start.
    eng_lat = 5;
    set_req(0, 1'b1, 7'h2A, 8'hC3);
    wait_ack(a);
    req[0] = 1'b0;
    check("w_ack", 32'(a), 32'h1);
    check("w_starts", 32'(starts), 32'd1);
    check("w_addr", 32'(st_addr), 32'h2A);
    check("w_din", 32'(st_din), 32'hC3);
    check("w_wr", 32'(st_wr), 32'd1);
    check("w_gnt", 32'(st_gnt), 32'h1);
    check("w_err", 32'(err), 32'd0);
    check("w_lat", 32'(ack_cyc - st_cyc), 32'd6);
    check("w_stable", 32'(unstable), 32'd0);
    check("w_rdata", 32'(rdata), 32'd0);
    tick();
    check("w_ack_pulse", 32'(ack), 32'd0);
    check("w_gnt_clr", 32'(gnt), 32'd0);

    // Read from requester 2.
    eng_lat = 3;
    eng_rd_val = 8'h5E;
    set_req(2, 1'b0, 7'h11, 8'h00);
    wait_ack(a);
    req[2] = 1'b0;
    check("r_ack", 32'(a), 32'h4);
    check("r_rdata", 32'(rdata), 32'h5E);
    check("r_addr", 32'(st_addr), 32'h11);
    check("r_wr", 32'(st_wr), 32'd0);
    check("r_err", 32'(err), 32'd0);
    tick();

    // Serve requester 1, then 0 and 1 together: 0 must win.
    eng_lat = 2;
    set_req(1, 1'b1, 7'h22, 8'h01);
    wait_ack(a);
    req[1] = 1'b0;
    check("p1_ack", 32'(a), 32'h2);
    check("p1_rdata_hold", 32'(rdata), 32'h5E);
    tick();
    set_req(0, 1'b1, 7'h30, 8'h02);
    set_req(1, 1'b1, 7'h31, 8'h03);
    wait_ack(a);
    req[0] = 1'b0;
    check("p2_ack0", 32'(a), 32'h1);
    check("p2_addr0", 32'(st_addr), 32'h30);
    tick();
    wait_ack(a);
    req[1] = 1'b0;
    check("p2_ack1", 32'(a), 32'h2);
    check("p2_addr1", 32'(st_addr), 32'h31);
    tick();

    // Requester drops req right after being granted.
    set_req(3, 1'b1, 7'h44, 8'h55);
    tick();
    check("drop_gnt", 32'(gnt), 32'h8);
    check("drop_start", 32'(eng_start), 32'd1);
    req[3] = 1'b0;
    wait_ack(a);
    check("drop_ack", 32'(a), 32'h8);
    tick();

    // All four request together after reset: order 0,1,2,3.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < NREQ; i++) begin
      per_ack[i] = 0;
      set_req(i, 1'b1, 7'(7'h10 + i), 8'(i));
    end
    for (int k = 0; k < NREQ; k++) begin
      wait_ack(a);
      check("rr_order", 32'(a), 32'(1 << k));
      check("rr_addr", 32'(st_addr), 32'(16 + k));
      for (int i = 0; i < NREQ; i++) if (a[i]) per_ack[i]++;
      req = req & ~a;
      tick();
    end
    extra = 0;
    for (int n = 0; n < 10; n++) begin
      if (ack != '0) extra++;
      tick();
    end
    check("rr_extra", 32'(extra), 32'd0);
    for (int i = 0; i < NREQ; i++) check("rr_once", 32'(per_ack[i]), 32'd1);

    // Reset while waiting on the engine.
    eng_en = 1'b0;
    set_req(0, 1'b0, 7'h01, 8'h00);
    tick(); tick(); tick(); tick();
    check("rw_gnt", 32'(gnt), 32'h1);
    rst = 1'b1;
    tick();
    check("rw_ctl", 32'({gnt, ack, eng_start, err}), 32'd0);
    check("rw_eng", 32'({eng_wr, eng_addr, eng_din}), 32'd0);
    check("rw_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    req = '0;
    extra = 0;
    for (int n = 0; n < 10; n++) begin
      if (ack != '0) extra++;
      tick();
    end
    check("rw_no_ack", 32'(extra), 32'd0);
    eng_en = 1'b1;
    eng_lat = 2;
    set_req(3, 1'b1, 7'h55, 8'hA5);
    wait_ack(a);
    req[3] = 1'b0;
    check("rw_ack3", 32'(a), 32'h8);
    check("rw_addr3", 32'(st_addr), 32'h55);
    check("rw_din3", 32'(st_din), 32'hA5);
    tick();

`ifdef I2C_ARB_TIMEOUT_EN
    eng_lat = 1;
    eng_rd_val = 8'h3C;
    set_req(2, 1'b0, 7'h12, 8'h00);
    wait_ack(a);
    req[2] = 1'b0;
    tick();
    check("to_pre_rdata", 32'(rdata), 32'h3C);
    eng_en = 1'b0;
    set_req(2, 1'b0, 7'h13, 8'h00);
    wait_ack(a);
    req[2] = 1'b0;
    check("to_ack", 32'(a), 32'h4);
    check("to_err", 32'(err), 32'd1);
    check("to_rdata", 32'(rdata), 32'h3C);
    check("to_lat", 32'(ack_cyc - st_cyc), 32'd17);
    tick();
    eng_en = 1'b1;
    eng_rd_val = 8'h77;
    set_req(1, 1'b0, 7'h14, 8'h00);
    wait_ack(a);
    req[1] = 1'b0;
    check("to_after_err", 32'(err), 32'd0);
    check("to_after_rdata", 32'(rdata), 32'h77);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
